// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - types and helpers shared by the fetch stage
package inst_fetch_pkg;

    // Contents of one IF/ID slot.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        valid;
        logic        adel;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{pc: 32'h0, inst: 32'h0, valid: 1'b0, adel: 1'b0};

    // Instruction fetches must be word aligned; anything else raises AdEL.
    function automatic logic fetch_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/inst_fetch_defines.sv
// rtl/inst_fetch_defines.sv - shared bus-width and constant macros for the fetch stage
`ifndef INST_FETCH_DEFINES_SV
`define INST_FETCH_DEFINES_SV

`define InstAddrBus 31:0
`define InstBus     31:0
`define ZEROWORD    32'h0000_0000
`define ChipEnable  1'b1
`define ChipDisable 1'b0
`define RstEnable_n 1'b0
`define PcStep      4
`define ResetPc     32'h0000_0000

`endif

// File: rtl/inst_fetch_if_id_reg.sv
// rtl/inst_fetch_if_id_reg.sv - IF/ID pipeline register with flush, bubble and hold
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   flush            exception flush: insert bubble
//   stall_if         fetch held this cycle
//   stall_id         decode held this cycle (with stall_if: hold slot)
//   rom_ce           fetch is live; when low the slot captures a bubble
//   pc, rom_inst     address and ROM word of the current fetch
//   id_pc, id_inst, id_valid, id_adel   registered slot contents
`include "inst_fetch_defines.sv"

module inst_fetch_if_id_reg
    import inst_fetch_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             stall_if,
    input  logic             stall_id,
    input  logic             rom_ce,
    input  logic [`InstAddrBus] pc,
    input  logic [`InstBus]  rom_inst,
    output logic [`InstAddrBus] id_pc,
    output logic [`InstBus]  id_inst,
    output logic             id_valid,
    output logic             id_adel
);

    if_id_t slot;
    if_id_t fetched;

    // A misaligned fetch still occupies the slot, but carries a nop so
    // nothing fetched from a bad address can execute.
    always_comb begin
        fetched       = IF_ID_BUBBLE;
        fetched.pc    = pc;
        fetched.valid = 1'b1;
        fetched.adel  = fetch_misaligned(pc);
        fetched.inst  = fetch_misaligned(pc) ? `ZEROWORD : rom_inst;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == `RstEnable_n) begin
            slot <= IF_ID_BUBBLE;
        end else if (flush) begin
            slot <= IF_ID_BUBBLE;
        end else if (stall_if && !stall_id) begin
            // Decode moves on but fetch has nothing new: feed it a bubble.
            slot <= IF_ID_BUBBLE;
        end else if (stall_if && stall_id) begin
            slot <= slot;
        end else if (rom_ce == `ChipDisable) begin
            slot <= IF_ID_BUBBLE;
        end else begin
            slot <= fetched;
        end
    end

    assign id_pc    = slot.pc;
    assign id_inst  = slot.inst;
    assign id_valid = slot.valid;
    assign id_adel  = slot.adel;

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - MIPS32 fetch stage: PC, ROM interface, pending branch, IF/ID
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   stall_if_i, stall_id_i     hazard-unit stalls
//   flush_i, new_pc_i          exception/eret redirect (highest priority)
//   branch_flag_i, branch_target_i   taken branch resolved in ID
//   rom_ce_o, rom_addr_o       ROM chip enable and byte address (= pc)
//   rom_inst_i                 combinational ROM word for rom_addr_o
//   id_pc_o, id_inst_o, id_valid_o, id_adel_o   IF/ID register outputs
`include "inst_fetch_defines.sv"

module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = `ResetPc,
    parameter int          PC_STEP  = `PcStep
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_if_i,
    input  logic             stall_id_i,
    input  logic             flush_i,
    input  logic [`InstAddrBus] new_pc_i,
    input  logic             branch_flag_i,
    input  logic [`InstAddrBus] branch_target_i,
    output logic             rom_ce_o,
    output logic [`InstAddrBus] rom_addr_o,
    input  logic [`InstBus]  rom_inst_i,
    output logic [`InstAddrBus] id_pc_o,
    output logic [`InstBus]  id_inst_o,
    output logic             id_valid_o,
    output logic             id_adel_o
);

    localparam logic [31:0] STEP = 32'(PC_STEP);

    logic [31:0] pc;
    logic        rom_ce;
    logic        pend_valid;
    logic [31:0] pend_target;

    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == `RstEnable_n) begin
            pc          <= RESET_PC;
            rom_ce      <= `ChipDisable;
            pend_valid  <= 1'b0;
            pend_target <= 32'h0;
        end else begin
            // The ROM is enabled one edge after reset release; the PC only
            // starts moving once a real fetch at RESET_PC has happened.
            rom_ce <= `ChipEnable;
            if (rom_ce == `ChipEnable) begin
                if (flush_i) begin
                    pc         <= new_pc_i;
                    pend_valid <= 1'b0;
                end else if (stall_if_i) begin
                    // A branch resolved while fetch is frozen would be lost;
                    // remember the first one and take it when the stall ends.
                    if (branch_flag_i && !pend_valid) begin
                        pend_valid  <= 1'b1;
                        pend_target <= branch_target_i;
                    end
                end else if (pend_valid) begin
                    pc         <= pend_target;
                    pend_valid <= 1'b0;
                end else if (branch_flag_i) begin
                    pc <= branch_target_i;
                end else begin
                    pc <= pc + STEP;
                end
            end
        end
    end

    assign rom_ce_o   = rom_ce;
    assign rom_addr_o = pc;

    inst_fetch_if_id_reg u_if_id_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush_i),
        .stall_if (stall_if_i),
        .stall_id (stall_id_i),
        .rom_ce   (rom_ce),
        .pc       (pc),
        .rom_inst (rom_inst_i),
        .id_pc    (id_pc_o),
        .id_inst  (id_inst_o),
        .id_valid (id_valid_o),
        .id_adel  (id_adel_o)
    );

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed self-checking bench for inst_fetch
`timescale 1ns/1ps

module tb_inst_fetch;

    logic        clk;
    logic        rst_n;
    logic        stall_if;
    logic        stall_id;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;
    logic        id_adel;

    int compared;
    int mismatched;

    inst_fetch dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_if_i      (stall_if),
        .stall_id_i      (stall_id),
        .flush_i         (flush),
        .new_pc_i        (new_pc),
        .branch_flag_i   (branch_flag),
        .branch_target_i (branch_target),
        .rom_ce_o        (rom_ce),
        .rom_addr_o      (rom_addr),
        .rom_inst_i      (rom_inst),
        .id_pc_o         (id_pc),
        .id_inst_o       (id_inst),
        .id_valid_o      (id_valid),
        .id_adel_o       (id_adel)
    );

    // ROM model: a recognisable word derived from the byte address.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    assign rom_inst = rom_word(rom_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full view of the observable state after an edge.
    task automatic check_all(input string tag, input logic [31:0] addr,
                             input logic [31:0] ipc, input logic [31:0] iinst,
                             input logic ivalid, input logic iadel);
        check({tag, ".addr"},  rom_addr, addr);
        check({tag, ".idpc"},  id_pc, ipc);
        check({tag, ".inst"},  id_inst, iinst);
        check({tag, ".valid"}, {31'h0, id_valid}, {31'h0, ivalid});
        check({tag, ".adel"},  {31'h0, id_adel}, {31'h0, iadel});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        compared      = 0;
        mismatched    = 0;
        rst_n         = 1'b0;
        stall_if      = 1'b0;
        stall_id      = 1'b0;
        flush         = 1'b0;
        new_pc        = 32'h0;
        branch_flag   = 1'b0;
        branch_target = 32'h0;

        #3;
        check("rst.ce", {31'h0, rom_ce}, 32'h0);
        check_all("rst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

        @(posedge clk); #2;
        rst_n = 1'b1;

        // First edge: ROM enabled, PC still at reset value, slot empty.
        step();
        check("e1.ce", {31'h0, rom_ce}, 32'h1);
        check_all("e1", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

        step(); check_all("seq4",  32'h4,  32'h0, rom_word(32'h0), 1'b1, 1'b0);
        step(); check_all("seq8",  32'h8,  32'h4, rom_word(32'h4), 1'b1, 1'b0);
        step(); check_all("seqC",  32'hC,  32'h8, rom_word(32'h8), 1'b1, 1'b0);
        step(); check_all("seq10", 32'h10, 32'hC, rom_word(32'hC), 1'b1, 1'b0);

        // Branch seen at pc=0x10: delay slot 0x10 enters IF/ID.
        branch_flag = 1'b1; branch_target = 32'h100;
        step(); check_all("br", 32'h100, 32'h10, rom_word(32'h10), 1'b1, 1'b0);
        branch_flag = 1'b0;
        step(); check_all("br+4", 32'h104, 32'h100, rom_word(32'h100), 1'b1, 1'b0);

        // Flush to 0x1C, then advance to pc=0x20.
        flush = 1'b1; new_pc = 32'h1C;
        step(); check_all("fl1C", 32'h1C, 32'h0, 32'h0, 1'b0, 1'b0);
        flush = 1'b0;
        step(); check_all("at20", 32'h20, 32'h1C, rom_word(32'h1C), 1'b1, 1'b0);

        // Full stall for three cycles: everything frozen.
        stall_if = 1'b1; stall_id = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); check_all("hold", 32'h20, 32'h1C, rom_word(32'h1C), 1'b1, 1'b0);
        end
        stall_if = 1'b0; stall_id = 1'b0;
        step(); check_all("resume", 32'h24, 32'h20, rom_word(32'h20), 1'b1, 1'b0);

        // Fetch-only stall: one bubble while PC holds.
        stall_if = 1'b1;
        step(); check_all("bubble", 32'h24, 32'h0, 32'h0, 1'b0, 1'b0);
        stall_if = 1'b0;
        step(); check_all("unbub", 32'h28, 32'h24, rom_word(32'h24), 1'b1, 1'b0);

        // Branch during stall is pended; a second branch does not overwrite it.
        stall_if = 1'b1; stall_id = 1'b1; branch_flag = 1'b1; branch_target = 32'h200;
        step(); check_all("pend1", 32'h28, 32'h24, rom_word(32'h24), 1'b1, 1'b0);
        branch_target = 32'h300;
        step(); check_all("pend2", 32'h28, 32'h24, rom_word(32'h24), 1'b1, 1'b0);
        stall_if = 1'b0; stall_id = 1'b0; branch_flag = 1'b0;
        step(); check_all("ptake", 32'h200, 32'h28, rom_word(32'h28), 1'b1, 1'b0);
        step(); check_all("p+4", 32'h204, 32'h200, rom_word(32'h200), 1'b1, 1'b0);

        // Pend a branch, then flush together with a new branch: flush wins, pend cleared.
        stall_if = 1'b1; stall_id = 1'b1; branch_flag = 1'b1; branch_target = 32'h300;
        step(); check_all("pend3", 32'h204, 32'h200, rom_word(32'h200), 1'b1, 1'b0);
        stall_if = 1'b0; stall_id = 1'b0;
        flush = 1'b1; new_pc = 32'h180; branch_target = 32'h400;
        step(); check_all("flbr", 32'h180, 32'h0, 32'h0, 1'b0, 1'b0);
        flush = 1'b0; branch_flag = 1'b0;
        step(); check_all("fl+4", 32'h184, 32'h180, rom_word(32'h180), 1'b1, 1'b0);

        // Misaligned branch target: tagged AdEL, nop in slot, no self-redirect.
        branch_flag = 1'b1; branch_target = 32'h102;
        step(); check_all("mis0", 32'h102, 32'h184, rom_word(32'h184), 1'b1, 1'b0);
        branch_flag = 1'b0;
        step(); check_all("mis1", 32'h106, 32'h102, 32'h0, 1'b1, 1'b1);

        // PC wraps from the top of the address space.
        flush = 1'b1; new_pc = 32'hFFFF_FFFC;
        step(); check_all("top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 1'b0);
        flush = 1'b0;
        step(); check_all("wrap", 32'h0, 32'hFFFF_FFFC, rom_word(32'hFFFF_FFFC), 1'b1, 1'b0);

        // Asynchronous reset mid-run, checked before any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.ce", {31'h0, rom_ce}, 32'h0);
        check_all("arst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Fetch stage of the 5-stage MIPS32 pipeline. It owns the PC and drives the instruction ROM's chip-enable and byte-address interface. It captures the ROM's same-cycle combinational word into the IF/ID pipeline register. It handles stalls, branch redirects (with delay slot), pending-branch latching under stall, exception flush and misaligned-fetch detection.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset.
PC_STEP, 4, byte increment per sequential fetch.

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall_if_i  in  1  hazard unit: hold PC and fetch
stall_id_i  in  1  hazard unit: ID stage held
flush_i  in  1  exception/eret flush, highest priority
new_pc_i  in  32  redirect target when flush_i=1
branch_flag_i  in  1  ID resolved a taken branch/jump
branch_target_i  in  32  target of that branch
rom_ce_o  out  1  ROM chip enable (`ChipEnable/`ChipDisable)
rom_addr_o  out  32  ROM byte address (= current PC)
rom_inst_i  in  32  ROM data, combinational from rom_addr_o
id_pc_o  out  32  IF/ID: PC of captured instruction
id_inst_o  out  32  IF/ID: instruction word
id_valid_o  out  1  IF/ID: slot holds a real instruction
id_adel_o  out  1  IF/ID: fetch address misaligned (AdEL)

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, rom_ce_o=0, id_pc_o=0, id_inst_o=`ZEROWORD, id_valid_o=0, id_adel_o=0, pend_valid=0, pend_target=0.
- First rising edge after rst_n deasserts: rom_ce_o becomes 1; pc stays RESET_PC. First real fetch is RESET_PC, visible in IF/ID one edge later.
- rom_addr_o = pc always. While rom_ce_o=0, rom_inst_i is ignored and the IF/ID capture is a bubble (valid=0, inst=0).
- Next-PC priority, evaluated each edge when rom_ce_o=1:
  1. flush_i: pc<=new_pc_i; pend cleared.
  2. stall_if_i: pc held. If branch_flag_i=1, latch pend_valid<=1, pend_target<=branch_target_i. A later branch never overwrites a set pend.
  3. pend_valid: pc<=pend_target; pend cleared.
  4. branch_flag_i: pc<=branch_target_i.
  5. Otherwise: pc<=pc+PC_STEP, mod 2^32 (32'hFFFF_FFFC wraps to 0).
- Delay slot: the instruction fetched in the same cycle branch_flag_i is seen enters IF/ID normally. It is not squashed.
- IF/ID register, per edge:
  1. flush_i: bubble (pc=0, inst=`ZEROWORD, valid=0, adel=0).
  2. stall_if_i=1 and stall_id_i=0: bubble.
  3. stall_if_i=1 and stall_id_i=1: hold all fields.
  4. Otherwise: id_pc<=pc, id_valid<=rom_ce_o, id_adel<=(pc[1:0]!=0), id_inst<=(pc[1:0]!=0) ? `ZEROWORD : rom_inst_i.
- Misaligned PC (from a branch or flush target): fetch proceeds, tagged adel, instruction forced to nop. The fetch unit does not self-redirect; it waits for flush_i from the exception logic.
- Reset mid-operation: all state, including pend, returns to reset values immediately, independent of clk.
- Latency: instruction at PC X appears on id_* exactly one edge after pc=X with no stall.

Decomposition:
- Use the shared defines header for `InstAddrBus, `InstBus, `ZEROWORD, `ChipEnable, `ChipDisable.
- Add to it: `RstEnable_n (1'b0), `PcStep (4), `ResetPc.
- Natural sub-module: if_id_reg (the IF/ID pipeline register with flush/bubble/hold logic), instantiated inside inst_fetch. PC and pending-branch logic stay in the top.

Test Plan:
- Reset release, no stalls -> rom_ce_o=1 after the first edge. rom_addr_o sequence is 0,4,8,C. id_pc_o trails by one edge and id_valid_o=1 from the second edge.
- branch_flag_i=1, target 0x100, while pc=0x10 -> 0x10 (delay slot) reaches IF/ID with valid=1. Next pc=0x100, then 0x104.
- stall_if_i=stall_id_i=1 for 3 cycles at pc=0x20 -> pc and id_* frozen. Resume gives 0x24.
- stall_if_i=1, stall_id_i=0 -> one bubble (valid=0, inst=0) inserted while pc holds.
- branch_flag_i=1 (target 0x200) during stall_if_i -> pend set. On stall release pc=0x200 with no 0x+4 step in between.
- flush_i=1 with new_pc_i=0x180 at the same edge as branch_flag_i -> pc=0x180, IF/ID bubble, pend cleared.
- Branch to 0x102 -> id_adel_o=1, id_inst_o=0, valid=1. Assert rst_n low mid-run -> all outputs to reset values without a clock edge.
